// File: rtl/vanilla_inst_encoder.sv
// RV32IM instruction encoder: op descriptors in, 32-bit instruction words out.
// Define BSG_VANILLA_ENC_PSEUDO_EN to expand LI/CALL into one or two words.
module vanilla_inst_encoder (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        v_i,
   output logic        ready_o,
   input  logic [3:0]  op_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic        v_o,
   output logic [31:0] instr_o,
   input  logic        ready_i,
   output logic        err_o
);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_ADDI  = 4'd2;
   localparam logic [3:0] OP_LUI   = 4'd3;
   localparam logic [3:0] OP_AUIPC = 4'd4;
   localparam logic [3:0] OP_LW    = 4'd5;
   localparam logic [3:0] OP_SW    = 4'd6;
   localparam logic [3:0] OP_BEQ   = 4'd7;
   localparam logic [3:0] OP_BNE   = 4'd8;
   localparam logic [3:0] OP_JAL   = 4'd9;
   localparam logic [3:0] OP_JALR  = 4'd10;
   localparam logic [3:0] OP_MUL   = 4'd11;
   localparam logic [3:0] OP_FENCE = 4'd12;
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
   localparam logic [3:0] OP_LI    = 4'd13;
   localparam logic [3:0] OP_CALL  = 4'd14;

   typedef enum logic [1:0] {S_IDLE, S_ONE, S_FIRST} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ONE} state_t;
`endif

   state_t      r_state;
   logic [31:0] r_instr;
   logic        r_err;

   logic [31:0] w_word0;
   logic        w_err;
   logic        w_acc;
   logic        w_s12;
   logic        w_br_ok;
   logic        w_jal_ok;
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
   logic [31:0] r_second;
   logic [31:0] w_word1;
   logic        w_two;
   logic [19:0] w_hi;

   // Upper field compensates for the sign extension of the low 12 bits.
   assign w_hi = imm_i[31:12] + {19'd0, imm_i[11]};
`endif

   assign w_s12    = (imm_i[31:11] == '0) | (imm_i[31:11] == '1);
   assign w_br_ok  = ~imm_i[0] & ((imm_i[31:12] == '0) | (imm_i[31:12] == '1));
   assign w_jal_ok = ~imm_i[0] & ((imm_i[31:20] == '0) | (imm_i[31:20] == '1));

   assign ready_o = (r_state == S_IDLE) | ((r_state == S_ONE) & ready_i);
   assign w_acc   = v_i & ready_o;
   assign v_o     = (r_state != S_IDLE);
   assign instr_o = r_instr;
   assign err_o   = r_err;

   always_comb begin
      w_word0 = '0;
      w_err   = 1'b0;
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
      w_word1 = '0;
      w_two   = 1'b0;
`endif
      case (op_i)
         OP_ADD:   w_word0 = {7'h00, rs2_i, rs1_i, 3'b000, rd_i, 7'h33};
         OP_SUB:   w_word0 = {7'h20, rs2_i, rs1_i, 3'b000, rd_i, 7'h33};
         OP_MUL:   w_word0 = {7'h01, rs2_i, rs1_i, 3'b000, rd_i, 7'h33};
         OP_ADDI: begin
            w_err   = ~w_s12;
            w_word0 = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'h13};
         end
         OP_LUI:   w_word0 = {imm_i[19:0], rd_i, 7'h37};
         OP_AUIPC: w_word0 = {imm_i[19:0], rd_i, 7'h17};
         OP_LW: begin
            w_err   = ~w_s12;
            w_word0 = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'h03};
         end
         OP_SW: begin
            w_err   = ~w_s12;
            w_word0 = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'h23};
         end
         OP_BEQ, OP_BNE: begin
            w_err   = ~w_br_ok;
            w_word0 = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 2'b00, (op_i == OP_BNE),
                       imm_i[4:1], imm_i[11], 7'h63};
         end
         OP_JAL: begin
            w_err   = ~w_jal_ok;
            w_word0 = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'h6F};
         end
         OP_JALR: begin
            w_err   = ~w_s12;
            w_word0 = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'h67};
         end
         OP_FENCE: w_word0 = 32'h0FF0000F;
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
         OP_LI: begin
            if (w_s12) begin
               w_word0 = {imm_i[11:0], 5'd0, 3'b000, rd_i, 7'h13};
            end else if (imm_i[11:0] == 12'd0) begin
               w_word0 = {imm_i[31:12], rd_i, 7'h37};
            end else begin
               w_word0 = {w_hi, rd_i, 7'h37};
               w_word1 = {imm_i[11:0], rd_i, 3'b000, rd_i, 7'h13};
               w_two   = 1'b1;
            end
         end
         OP_CALL: begin
            w_err   = imm_i[0];
            w_word0 = {w_hi, rd_i, 7'h17};
            w_word1 = {imm_i[11:0], rd_i, 3'b000, rd_i, 7'h67};
            w_two   = 1'b1;
         end
`endif
         default:  w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state  <= S_IDLE;
         r_instr  <= '0;
         r_err    <= 1'b0;
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
         r_second <= '0;
`endif
      end else begin
         r_err <= w_acc & w_err;
         case (r_state)
            S_IDLE, S_ONE: begin
               if (w_acc) begin
                  // A rejected descriptor leaves nothing pending.
                  if (w_err) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_instr <= w_word0;
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
                     r_second <= w_word1;
                     r_state  <= w_two ? S_FIRST : S_ONE;
`else
                     r_state  <= S_ONE;
`endif
                  end
               end else if ((r_state == S_ONE) && ready_i) begin
                  r_state <= S_IDLE;
               end
            end
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
            S_FIRST: begin
               if (ready_i) begin
                  r_instr <= r_second;
                  r_state <= S_ONE;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vanilla_inst_encoder.sv
// Self-checking bench for vanilla_inst_encoder: directed test-plan cases plus
// randomized descriptors checked every cycle against a queue-based model.
module tb_vanilla_inst_encoder;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        v_i;
   logic        ready_o;
   logic [3:0]  op_i;
   logic [4:0]  rd_i, rs1_i, rs2_i;
   logic [31:0] imm_i;
   logic        v_o;
   logic [31:0] instr_o;
   logic        ready_i = 1'b1;
   logic        err_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] log_q[$];
   bit          exp_err = 1'b0;
   bit          mon_en  = 1'b0;
   int          dut_err_cnt = 0;
   bit          rdy_manual = 1'b1;
   bit          rdy_val    = 1'b1;

   always #5 clk = ~clk;

   vanilla_inst_encoder dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .v_i     (v_i),
      .ready_o (ready_o),
      .op_i    (op_i),
      .rd_i    (rd_i),
      .rs1_i   (rs1_i),
      .rs2_i   (rs2_i),
      .imm_i   (imm_i),
      .v_o     (v_o),
      .instr_o (instr_o),
      .ready_i (ready_i),
      .err_o   (err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] enc_r(input int f7, input logic [4:0] rs2, rs1,
                                         input int f3, input logic [4:0] rd, input int opc);
      return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
             | (32'(rd) << 7) | 32'(opc);
   endfunction

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input int f3, input logic [4:0] rd, input int opc);
      return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
   endfunction

   function automatic logic [31:0] enc_u(input logic [31:0] upper, input logic [4:0] rd, input int opc);
      return ((upper & 32'hFFFFF) << 12) | (32'(rd) << 7) | 32'(opc);
   endfunction

   function automatic logic [31:0] bitof(input logic [31:0] v, input int b);
      return (v >> b) & 32'd1;
   endfunction

   function automatic void model(input logic [3:0] op, input logic [4:0] rd, rs1, rs2,
                                 input logic [31:0] imm, output bit err, output int n,
                                 output logic [31:0] w0, output logic [31:0] w1);
      int s;
      bit in12;
      logic [31:0] hi;
      s    = int'($signed(imm));
      in12 = (s >= -2048) && (s <= 2047);
      hi   = ((imm + 32'h800) >> 12) & 32'hFFFFF;
      err = 1'b0; n = 1; w0 = '0; w1 = '0;
      case (op)
         4'd0:  w0 = enc_r(0, rs2, rs1, 0, rd, 'h33);
         4'd1:  w0 = enc_r(32, rs2, rs1, 0, rd, 'h33);
         4'd11: w0 = enc_r(1, rs2, rs1, 0, rd, 'h33);
         4'd2:  begin err = !in12; w0 = enc_i(imm, rs1, 0, rd, 'h13); end
         4'd3:  w0 = enc_u(imm, rd, 'h37);
         4'd4:  w0 = enc_u(imm, rd, 'h17);
         4'd5:  begin err = !in12; w0 = enc_i(imm, rs1, 2, rd, 'h03); end
         4'd6:  begin
            err = !in12;
            w0 = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                 | (32'd2 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
         end
         4'd7, 4'd8: begin
            err = (s % 2 != 0) || (s < -4096) || (s > 4094);
            w0 = (bitof(imm, 12) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                 | (32'(rs1) << 15) | ((op == 4'd8 ? 32'd1 : 32'd0) << 12)
                 | (((imm >> 1) & 32'hF) << 8) | (bitof(imm, 11) << 7) | 32'h63;
         end
         4'd9: begin
            err = (s % 2 != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 2);
            w0 = (bitof(imm, 20) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (bitof(imm, 11) << 20)
                 | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
         end
         4'd10: begin err = !in12; w0 = enc_i(imm, rs1, 0, rd, 'h67); end
         4'd12: w0 = 32'h0FF0000F;
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
         4'd13: begin
            if (in12) w0 = enc_i(imm, 5'd0, 0, rd, 'h13);
            else if ((imm & 32'hFFF) == 0) w0 = enc_u(imm >> 12, rd, 'h37);
            else begin n = 2; w0 = enc_u(hi, rd, 'h37); w1 = enc_i(imm, rd, 0, rd, 'h13); end
         end
         4'd14: begin
            err = (s % 2 != 0);
            n = 2; w0 = enc_u(hi, rd, 'h17); w1 = enc_i(imm, rd, 0, rd, 'h67);
         end
`endif
         default: err = 1'b1;
      endcase
   endfunction

   // ---------------- ready_i generator ----------------
   always @(posedge clk) begin
      #2;
      if (rdy_manual) ready_i = rdy_val;
      else ready_i = ($urandom_range(0, 99) < 70);
   end

   // ---------------- per-cycle compare process ----------------
   always @(negedge clk) begin
      bit          m_err;
      int          m_n;
      logic [31:0] m_w0, m_w1;
      bit          exp_rdy;
      if (mon_en) begin
         exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ready_i);
         chk("v_o", 32'(v_o), 32'(exp_q.size() != 0));
         chk("err_o", 32'(err_o), 32'(exp_err));
         chk("ready_o", 32'(ready_o), 32'(exp_rdy));
         if (exp_q.size() != 0) chk("instr_o", instr_o, exp_q[0]);
         if (v_o === 1'b1 && ready_i) log_q.push_back(instr_o);
         if (err_o === 1'b1) dut_err_cnt++;
         if (reset_i) begin
            exp_q.delete();
            exp_err = 1'b0;
         end else begin
            exp_err = 1'b0;
            if (exp_q.size() != 0 && ready_i) void'(exp_q.pop_front());
            if (v_i && exp_rdy) begin
               model(op_i, rd_i, rs1_i, rs2_i, imm_i, m_err, m_n, m_w0, m_w1);
               if (m_err) exp_err = 1'b1;
               else begin
                  exp_q.push_back(m_w0);
                  if (m_n == 2) exp_q.push_back(m_w1);
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, output int waited);
      bit acc;
      op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm; v_i = 1'b1;
      waited = 0; acc = 1'b0;
      while (!acc && waited < 100) begin
         @(negedge clk);
         acc = ready_o;
         @(posedge clk); #1;
         if (!acc) waited++;
      end
      v_i = 1'b0;
      if (!acc) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: op %0d not accepted within 100 cycles", op);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
      if (idx >= log_q.size()) begin
         n_tests++; n_fail++;
         $display("FAIL %s: word %0d missing (got %0d words) expected 0x%08h", name, idx, log_q.size(), exp);
      end else begin
         chk(name, log_q[idx], exp);
      end
   endtask

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 6))
         0: return 32'($urandom_range(0, 4095)) - 32'd2048;
         1: return $urandom();
         2: return 32'($urandom_range(0, 8191)) - 32'd4096;
         3: return 32'($urandom_range(0, 2097151)) - 32'h100000;
         4: return $urandom() & 32'hFFFFF000;
         5: case ($urandom_range(0, 7))
               0: return 32'd2047;
               1: return 32'd2048;
               2: return 32'hFFFFF800;
               3: return 32'hFFFFF7FF;
               4: return 32'd4094;
               5: return 32'd4096;
               6: return 32'hFFFFF000;
               default: return 32'h000FFFFE;
            endcase
         default: return 32'hFFF00000;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int w, base, e0;
      reset_i = 1'b1; v_i = 1'b0; op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
      cycles(3);
      mon_en = 1'b1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst_v_o", 32'(v_o), 32'd0);
      chk("rst_err_o", 32'(err_o), 32'd0);
      chk("rst_instr_o", instr_o, 32'd0);
      chk("rst_ready_o", 32'(ready_o), 32'd1);
      @(posedge clk); #1;

      // ADDI / ADD / MUL back to back
      base = log_q.size();
      send(4'd2, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, w);
      chk("addi_wait", 32'(w), 32'd0);
      chk("addi_lat_v", 32'(v_o), 32'd1);
      chk("addi_lat_instr", instr_o, 32'hFFF00293);
      send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, w);
      chk("add_wait", 32'(w), 32'd0);
      send(4'd11, 5'd3, 5'd1, 5'd2, 32'd0, w);
      cycles(3);
      chk_log("addi_word", base, 32'hFFF00293);
      chk_log("add_word", base + 1, 32'h002081B3);
      chk_log("mul_word", base + 2, 32'h022081B3);

      base = log_q.size();
      send(4'd3, 5'd1, 5'd0, 5'd0, 32'h00012345, w);
      send(4'd12, 5'd0, 5'd0, 5'd0, 32'd0, w);
      cycles(3);
      chk_log("lui_word", base, 32'h123450B7);
      chk_log("fence_word", base + 1, 32'h0FF0000F);

`ifdef BSG_VANILLA_ENC_PSEUDO_EN
      // LI pair with FIRST-state backpressure on ready_o
      base = log_q.size();
      rdy_val = 1'b0;
      send(4'd13, 5'd10, 5'd0, 5'd0, 32'h12345FFF, w);
      rdy_val = 1'b1;
      #2;
      chk("li_first_ready_o", 32'(ready_o), 32'd0);
      chk("li_first_instr", instr_o, 32'h12346537);
      cycles(4);
      send(4'd13, 5'd10, 5'd0, 5'd0, 32'h00001000, w);
      cycles(3);
      chk_log("li_w0", base, 32'h12346537);
      chk_log("li_w1", base + 1, 32'hFFF50513);
      chk_log("li_single", base + 2, 32'h00001537);
      chk("li_count", 32'(log_q.size() - base), 32'd3);

      // CALL with ready_i held low for 3 cycles on each word
      base = log_q.size();
      rdy_val = 1'b0;
      send(4'd14, 5'd1, 5'd0, 5'd0, 32'h00000800, w);
      cycles(3);
      rdy_val = 1'b1;
      cycles(1);
      rdy_val = 1'b0;
      cycles(3);
      rdy_val = 1'b1;
      cycles(4);
      chk_log("call_w0", base, 32'h00001097);
      chk_log("call_w1", base + 1, 32'h800080E7);
      chk("call_count", 32'(log_q.size() - base), 32'd2);
`else
      base = log_q.size();
      e0 = dut_err_cnt;
      send(4'd13, 5'd10, 5'd0, 5'd0, 32'h12345FFF, w);
      cycles(3);
      chk("li_err_pulse", 32'(dut_err_cnt - e0), 32'd1);
      e0 = dut_err_cnt;
      send(4'd14, 5'd1, 5'd0, 5'd0, 32'h00000800, w);
      cycles(3);
      chk("call_err_pulse", 32'(dut_err_cnt - e0), 32'd1);
      chk("pseudo_no_words", 32'(log_q.size() - base), 32'd0);
`endif

      // range-check errors
      base = log_q.size();
      e0 = dut_err_cnt;
      send(4'd7, 5'd0, 5'd1, 5'd2, 32'd3, w);
      cycles(2);
      chk("beq_err_pulse", 32'(dut_err_cnt - e0), 32'd1);
      chk("beq_err_idle", 32'(ready_o), 32'd1);
      e0 = dut_err_cnt;
      send(4'd2, 5'd5, 5'd0, 5'd0, 32'd2048, w);
      cycles(2);
      chk("addi_err_pulse", 32'(dut_err_cnt - e0), 32'd1);
      chk("err_no_words", 32'(log_q.size() - base), 32'd0);

      // reset with a word pending drops it
      base = log_q.size();
      rdy_val = 1'b0;
`ifdef BSG_VANILLA_ENC_PSEUDO_EN
      send(4'd13, 5'd10, 5'd0, 5'd0, 32'h12345FFF, w);
`else
      send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, w);
`endif
      reset_i = 1'b1;
      cycles(1);
      reset_i = 1'b0;
      rdy_val = 1'b1;
      cycles(5);
      chk("rst_pending_v_o", 32'(v_o), 32'd0);
      chk("rst_pending_words", 32'(log_q.size() - base), 32'd0);

      // randomized phase
      rdy_manual = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_i = 1'b1;
            cycles(1);
            reset_i = 1'b0;
         end
         if ($urandom_range(0, 4) == 0) cycles($urandom_range(1, 3));
         send(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), rand_imm(), w);
      end
      rdy_manual = 1'b1;
      rdy_val = 1'b1;
      cycles(6);
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
